// File: rtl/arbitro_operacao_if.sv
// Requester and arithmetic-unit signal bundle around the round-robin operation arbiter.
interface arbitro_operacao_if;
    logic       Req0;
    logic       Req1;
    logic [3:0] A0;
    logic [3:0] B0;
    logic [3:0] A1;
    logic [3:0] B1;
    logic       Op0;
    logic       Op1;
    logic       Gnt0;
    logic       Gnt1;
    logic       Done0;
    logic       Done1;
    logic [4:0] Resultado;
    logic       Sinal;
    logic       Erro;
    logic [3:0] A_alu;
    logic [3:0] B_alu;
    logic       Oper_alu;
    logic       Hab_alu;
    logic [4:0] Result_alu;
    logic       Sinal_alu;
    logic       Fim_alu;

    modport slave (
        input  Req0, Req1, A0, B0, A1, B1, Op0, Op1,
        input  Result_alu, Sinal_alu, Fim_alu,
        output Gnt0, Gnt1, Done0, Done1, Resultado, Sinal, Erro,
        output A_alu, B_alu, Oper_alu, Hab_alu
    );

    modport master (
        output Req0, Req1, A0, B0, A1, B1, Op0, Op1,
        output Result_alu, Sinal_alu, Fim_alu,
        input  Gnt0, Gnt1, Done0, Done1, Resultado, Sinal, Erro,
        input  A_alu, B_alu, Oper_alu, Hab_alu
    );
endinterface

// File: rtl/arbitro_operacao.sv
// Round-robin arbiter/sequencer sharing one 4-bit add/subtract unit between two requesters.
module arbitro_operacao #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    arbitro_operacao_if.slave bus
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 5;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ESPERA = 2'd1,
        LIBERA = 2'd2
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ultimo_q, ultimo_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [RES_W-1:0]    resultado_q, resultado_d;
    logic                sinal_q, sinal_d;
    logic                erro_q, erro_d;
    logic [OPND_W-1:0]   a_q, a_d;
    logic [OPND_W-1:0]   b_q, b_d;
    logic                oper_q, oper_d;
    logic                hab_q, hab_d;
    logic                sel0_c;

    // Requester 0 wins when alone, or on a tie when requester 1 was served last.
    assign sel0_c = bus.Req0 & (~bus.Req1 | ultimo_q);

    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        ultimo_d    = ultimo_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        resultado_d = resultado_q;
        sinal_d     = sinal_q;
        erro_d      = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        oper_d      = oper_q;
        hab_d       = hab_q;

        case (estado_q)
            OCIOSO: begin
                hab_d  = 1'b0;
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                if (bus.Req0 || bus.Req1) begin
                    a_d      = sel0_c ? bus.A0  : bus.A1;
                    b_d      = sel0_c ? bus.B0  : bus.B1;
                    oper_d   = sel0_c ? bus.Op0 : bus.Op1;
                    gnt0_d   = sel0_c;
                    gnt1_d   = ~sel0_c;
                    ultimo_d = ~sel0_c;
                    hab_d    = 1'b1;
                    cnt_d    = '0;
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.Fim_alu) begin
                    resultado_d = bus.Result_alu;
                    sinal_d     = bus.Sinal_alu;
                    done0_d     = gnt0_q;
                    done1_d     = gnt1_q;
                    hab_d       = 1'b0;
                    estado_d    = LIBERA;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resultado_d = '0;
                    sinal_d     = 1'b0;
                    done0_d     = gnt0_q;
                    done1_d     = gnt1_q;
                    erro_d      = 1'b1;
                    hab_d       = 1'b0;
                    estado_d    = LIBERA;
                end
            end
            LIBERA: begin
                hab_d = 1'b0;
                // Hold the grant until the unit has dropped its completion flag.
                if (!bus.Fim_alu) begin
                    gnt0_d   = 1'b0;
                    gnt1_d   = 1'b0;
                    estado_d = OCIOSO;
                end
            end
            default: begin
                hab_d    = 1'b0;
                gnt0_d   = 1'b0;
                gnt1_d   = 1'b0;
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= OCIOSO;
            cnt_q       <= '0;
            ultimo_q    <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            resultado_q <= '0;
            sinal_q     <= 1'b0;
            erro_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            oper_q      <= 1'b0;
            hab_q       <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            ultimo_q    <= ultimo_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            resultado_q <= resultado_d;
            sinal_q     <= sinal_d;
            erro_q      <= erro_d;
            a_q         <= a_d;
            b_q         <= b_d;
            oper_q      <= oper_d;
            hab_q       <= hab_d;
        end
    end

    assign bus.Gnt0      = gnt0_q;
    assign bus.Gnt1      = gnt1_q;
    assign bus.Done0     = done0_q;
    assign bus.Done1     = done1_q;
    assign bus.Resultado = resultado_q;
    assign bus.Sinal     = sinal_q;
    assign bus.Erro      = erro_q;
    assign bus.A_alu     = a_q;
    assign bus.B_alu     = b_q;
    assign bus.Oper_alu  = oper_q;
    assign bus.Hab_alu   = hab_q;

endmodule

// File: tb/tb_arbitro_operacao.sv
// Directed bench for arbitro_operacao with a behavioural add/subtract unit that can be stuck.
module tb_arbitro_operacao;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   both_gnt;
    int   n;
    int   alu_mode;   // 0 = nominal unit, 1 = Fim stuck 0, 2 = Fim stuck 1

    arbitro_operacao_if bus ();

    arbitro_operacao #(.TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural arithmetic unit: registers the result, raises Fim once it matches.
    logic [4:0] comp_r;
    logic       comp_s;
    logic [4:0] res_m;
    logic       sgn_m;
    logic       v_m;
    logic       fim_m;

    always_comb begin
        comp_r = 5'd0;
        comp_s = 1'b0;
        if (!bus.Oper_alu) begin
            comp_r = 5'(bus.A_alu) + 5'(bus.B_alu);
        end else if (bus.A_alu >= bus.B_alu) begin
            comp_r = 5'(bus.A_alu) - 5'(bus.B_alu);
        end else begin
            comp_r = 5'(bus.B_alu) - 5'(bus.A_alu);
            comp_s = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            res_m <= 5'd0;
            sgn_m <= 1'b0;
            v_m   <= 1'b0;
            fim_m <= 1'b0;
        end else begin
            v_m <= bus.Hab_alu;
            if (bus.Hab_alu) begin
                res_m <= comp_r;
                sgn_m <= comp_s;
            end
            fim_m <= bus.Hab_alu && v_m && (res_m == comp_r) && (sgn_m == comp_s);
        end
    end

    assign bus.Result_alu = res_m;
    assign bus.Sinal_alu  = sgn_m;
    assign bus.Fim_alu    = (alu_mode == 0) ? fim_m : (alu_mode == 2);

    always @(negedge clk) begin
        if (bus.Gnt0 && bus.Gnt1) both_gnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    // Counts negedges until a Done pulse is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.Done0 || bus.Done1) && cyc < 60);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.Gnt0, bus.Gnt1, bus.Done0, bus.Done1, bus.Resultado, bus.Sinal,
                    bus.Erro, bus.A_alu, bus.B_alu, bus.Oper_alu, bus.Hab_alu});
    endfunction

    initial begin
        vectors = 0; miscompares = 0; both_gnt = 0; alu_mode = 0;
        rst = 1'b1;
        bus.Req0 = 0; bus.Req1 = 0; bus.Op0 = 0; bus.Op1 = 0;
        bus.A0 = 0; bus.B0 = 0; bus.A1 = 0; bus.B1 = 0;
        tick(3);
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;

        // Add 9+4 on requester 0; Done visible 3 edges after the sampling edge.
        bus.Req0 = 1; bus.A0 = 4'd9; bus.B0 = 4'd4; bus.Op0 = 0;
        tick(1);
        check("t1_gnt0", 32'(bus.Gnt0), 32'd1);
        check("t1_hab", 32'(bus.Hab_alu), 32'd1);
        check("t1_a_alu", 32'(bus.A_alu), 32'd9);
        tick(2);
        check("t1_done_early", 32'(bus.Done0), 32'd0);
        tick(1);
        check("t1_done0", 32'(bus.Done0), 32'd1);
        check("t1_resultado", 32'(bus.Resultado), 32'd13);
        check("t1_sinal_erro", 32'({bus.Sinal, bus.Erro}), 32'd0);
        check("t1_hab_off", 32'(bus.Hab_alu), 32'd0);
        bus.Req0 = 0;
        tick(1);
        check("t1_done_pulse", 32'({bus.Done0, bus.Gnt0}), 32'b01);
        tick(1);
        check("t1_gnt_release", 32'(bus.Gnt0), 32'd0);
        check("t1_hold_res", 32'(bus.Resultado), 32'd13);

        // Subtract 3-12 on requester 1.
        bus.Req1 = 1; bus.A1 = 4'd3; bus.B1 = 4'd12; bus.Op1 = 1;
        wait_done(n);
        check("t2_latency", 32'(n), 32'd4);
        check("t2_done1", 32'({bus.Done0, bus.Done1}), 32'b01);
        check("t2_resultado", 32'(bus.Resultado), 32'd9);
        check("t2_sinal", 32'(bus.Sinal), 32'd1);
        bus.Req1 = 0;
        tick(2);

        // Tie held: last served was 1, so order is 0,1,0,1 every 6 cycles.
        bus.Req0 = 1; bus.A0 = 4'd1; bus.B0 = 4'd2; bus.Op0 = 0;
        bus.Req1 = 1; bus.A1 = 4'd5; bus.B1 = 4'd7; bus.Op1 = 1;
        for (int k = 0; k < 4; k++) begin
            wait_done(n);
            check("t3_spacing", 32'(n), (k == 0) ? 32'd4 : 32'd6);
            check("t3_who", 32'({bus.Done0, bus.Done1}), (k % 2 == 0) ? 32'b10 : 32'b01);
            check("t3_resultado", 32'(bus.Resultado), (k % 2 == 0) ? 32'd3 : 32'd2);
        end
        bus.Req0 = 0; bus.Req1 = 0;
        tick(2);
        check("t3_no_double_gnt", 32'(both_gnt), 32'd0);

        // Operand change while waiting on the unit must not leak through.
        bus.Req0 = 1; bus.A0 = 4'd15; bus.B0 = 4'd15; bus.Op0 = 0;
        tick(2);
        bus.A0 = 4'd0;
        check("t4_frozen", 32'(bus.A_alu), 32'd15);
        wait_done(n);
        check("t4_latency", 32'(n), 32'd2);
        check("t4_resultado", 32'(bus.Resultado), 32'd30);
        bus.Req0 = 0;
        tick(2);

        // Fim stuck low: abort with Erro 15 cycles after grant.
        alu_mode = 1;
        bus.Req0 = 1; bus.A0 = 4'd2; bus.B0 = 4'd3; bus.Op0 = 0;
        tick(1);
        check("t5_gnt0", 32'(bus.Gnt0), 32'd1);
        wait_done(n);
        check("t5_timeout_cycles", 32'(n), 32'd15);
        check("t5_done_erro", 32'({bus.Done0, bus.Erro}), 32'b11);
        check("t5_res_zero", 32'({bus.Resultado, bus.Sinal}), 32'd0);
        check("t5_hab_low", 32'(bus.Hab_alu), 32'd0);
        bus.Req0 = 0;
        tick(1);
        check("t5_erro_pulse", 32'({bus.Done0, bus.Erro, bus.Gnt0}), 32'd0);

        // Fim stuck high: sits in LIBERA until Fim drops.
        alu_mode = 2;
        bus.Req1 = 1; bus.A1 = 4'd1; bus.B1 = 4'd1; bus.Op1 = 0;
        wait_done(n);
        check("t6_latency", 32'(n), 32'd2);
        check("t6_done1_ok", 32'({bus.Done1, bus.Erro}), 32'b10);
        bus.Req1 = 0;
        tick(5);
        check("t6_stuck_gnt", 32'({bus.Gnt1, bus.Hab_alu}), 32'b10);
        alu_mode = 0;
        tick(1);
        check("t6_recover", 32'(bus.Gnt1), 32'd0);

        // Reset while waiting: everything clears and the tie pointer restarts at 0.
        bus.Req0 = 1; bus.A0 = 4'd7; bus.B0 = 4'd1; bus.Op0 = 1;
        tick(2);
        check("t7_in_espera", 32'({bus.Gnt0, bus.Hab_alu}), 32'b11);
        rst = 1'b1; bus.Req0 = 0;
        tick(1);
        check("t7_reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;
        bus.Req0 = 1; bus.Req1 = 1;
        tick(1);
        check("t7_tie_after_reset", 32'({bus.Gnt0, bus.Gnt1}), 32'b10);
        wait_done(n);
        check("t7_latency", 32'(n), 32'd3);
        check("t7_result", 32'({bus.Done0, bus.Resultado, bus.Sinal}), 32'({1'b1, 5'd6, 1'b0}));
        bus.Req0 = 0; bus.Req1 = 0;
        tick(3);
        check("final_no_double_gnt", 32'(both_gnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
